// File: rtl/chip8_pkg.sv
// chip8_pkg -- shared types and helpers for the CHIP-8/SUPER-CHIP display path.
//   state_t         : sprite blitter sequencer states
//   DEFAULT_DISP_W/H: classic 64x32 display geometry
//   pix_index()     : framebuffer bit index of pixel (x, y), row-major
package chip8_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_PLOT,
        S_DONE
    } state_t;

    localparam int DEFAULT_DISP_W = 64;
    localparam int DEFAULT_DISP_H = 32;

    function automatic int pix_index(input int x, input int y, input int disp_w);
        return y * disp_w + x;
    endfunction

endpackage

// File: rtl/chip8_sprite_row_xor.sv
// chip8_sprite_row_xor -- combinational XOR of one sprite row into the framebuffer.
//   i_row_buf  : row pixels; narrow rows use [7:0], wide rows use [15:0] (MSB leftmost)
//   i_wide     : 1 = 16-pixel row, 0 = 8-pixel row
//   i_x0       : row origin X (already reduced modulo DISP_W)
//   i_py       : unreduced row Y (y0 + row), may exceed DISP_H
//   i_clip     : 1 = drop off-screen pixels, 0 = wrap them
//   i_fb       : current framebuffer
//   o_fb_next  : framebuffer after the row is XORed in
//   o_row_coll : some pixel of this row turned a lit pixel off
module chip8_sprite_row_xor
    import chip8_pkg::*;
#(
    parameter int DISP_W = DEFAULT_DISP_W,
    parameter int DISP_H = DEFAULT_DISP_H
) (
    input  logic [15:0]                i_row_buf,
    input  logic                       i_wide,
    input  logic [$clog2(DISP_W)-1:0]  i_x0,
    input  logic [7:0]                 i_py,
    input  logic                       i_clip,
    input  logic [DISP_W*DISP_H-1:0]   i_fb,
    output logic [DISP_W*DISP_H-1:0]   o_fb_next,
    output logic                       o_row_coll
);

    localparam int XW   = $clog2(DISP_W);
    localparam int YW   = $clog2(DISP_H);
    localparam int IW   = $clog2(DISP_W * DISP_H);

    logic [15:0]   w_bits;
    logic [7:0]    w_px;
    logic          w_in_bounds;
    logic [IW-1:0] w_idx;

    // Left-align narrow rows so bit 15-k is always pixel k.
    assign w_bits = i_wide ? i_row_buf : {i_row_buf[7:0], 8'h00};

    // Pixels are toggled in order so that a wide row wrapping onto itself on a
    // narrow display sees its own earlier toggles, like a sequential plot would.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        o_fb_next   = i_fb;
        o_row_coll  = 1'b0;
        w_px        = '0;
        w_in_bounds = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < 16; k++) begin
            w_px        = 8'(i_x0) + 8'(k);
            w_in_bounds = (int'(w_px) < DISP_W) && (int'(i_py) < DISP_H);
            // Power-of-two geometry: the low bits are the wrapped coordinate.
            w_idx = IW'(pix_index(int'(w_px[XW-1:0]), int'(i_py[YW-1:0]), DISP_W));
            if (w_bits[15-k] && (k < 8 || i_wide) && (!i_clip || w_in_bounds)) begin
                if (o_fb_next[w_idx])
                    o_row_coll = 1'b1;
                o_fb_next[w_idx] = ~o_fb_next[w_idx];
            end
        end
    end

endmodule

// File: rtl/chip8_sprite_blitter.sv
// chip8_sprite_blitter -- Dxyn sprite draw engine with internal framebuffer.
//   clk, reset            : clock, asynchronous active-high reset
//   i_start / i_clear     : draw / clear command strobes, sampled only when idle
//   i_x_in, i_y_in        : sprite origin (reduced modulo display size)
//   i_n_rows, i_wide_en   : sprite height; 0 = 16x16 when wide enabled, else no-op
//   i_clip                : 1 = clip at display edges, 0 = wrap
//   i_base_addr           : sprite address in program RAM
//   o_mem_rd, o_mem_addr  : synchronous RAM read port, i_mem_data valid next cycle
//   o_busy, o_done        : command in progress / one-cycle completion pulse
//   o_collision           : VF result of the last draw
//   o_display             : framebuffer, bit y*DISP_W + x
module chip8_sprite_blitter
    import chip8_pkg::*;
#(
    parameter int DISP_W = DEFAULT_DISP_W,
    parameter int DISP_H = DEFAULT_DISP_H,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic                      i_clear,
    input  logic [7:0]                i_x_in,
    input  logic [7:0]                i_y_in,
    input  logic [3:0]                i_n_rows,
    input  logic                      i_wide_en,
    input  logic                      i_clip,
    input  logic [ADDR_W-1:0]         i_base_addr,
    output logic                      o_mem_rd,
    output logic [ADDR_W-1:0]         o_mem_addr,
    input  logic [7:0]                i_mem_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_collision,
    output logic [DISP_W*DISP_H-1:0]  o_display
);

    localparam int XW   = $clog2(DISP_W);
    localparam int YW   = $clog2(DISP_H);
    localparam int NPIX = DISP_W * DISP_H;

    state_t            r_state;
    logic [XW-1:0]     r_x0;
    logic [YW-1:0]     r_y0;
    logic              r_clip;
    logic              r_wide;
    logic              r_byte;
    logic [3:0]        r_row;
    logic [3:0]        r_last;
    logic [15:0]       r_row_buf;
    logic              r_coll_acc;
    logic              r_collision;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NPIX-1:0]   r_display;

    logic [7:0]        w_py;
    logic [NPIX-1:0]   w_fb_next;
    logic              w_row_coll;

    assign w_py = 8'(r_y0) + 8'(r_row);

    chip8_sprite_row_xor #(
        .DISP_W (DISP_W),
        .DISP_H (DISP_H)
    ) u_row_xor (
        .i_row_buf  (r_row_buf),
        .i_wide     (r_wide),
        .i_x0       (r_x0),
        .i_py       (w_py),
        .i_clip     (r_clip),
        .i_fb       (r_display),
        .o_fb_next  (w_fb_next),
        .o_row_coll (w_row_coll)
    );

    // Bytes are fetched at consecutive addresses, so the read address simply
    // increments from base; it wraps modulo 2^ADDR_W by register width.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_clip      <= 1'b0;
            r_wide      <= 1'b0;
            r_byte      <= 1'b0;
            r_row       <= '0;
            r_last      <= '0;
            r_row_buf   <= '0;
            r_coll_acc  <= 1'b0;
            r_collision <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            // NOTE: the framebuffer is plain flops, not RAM, so it can and must clear on reset.
            r_display   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clear) begin
                        r_display <= '0;
                    end else if (i_start) begin
                        r_x0        <= XW'(i_x_in % DISP_W);
                        r_y0        <= YW'(i_y_in % DISP_H);
                        r_clip      <= i_clip;
                        r_wide      <= (i_n_rows == 4'd0);
                        r_last      <= (i_n_rows == 4'd0) ? 4'd15 : i_n_rows - 4'd1;
                        r_row       <= '0;
                        r_byte      <= 1'b0;
                        r_coll_acc  <= 1'b0;
                        r_collision <= 1'b0;
                        r_busy      <= 1'b1;
                        if (i_n_rows == 4'd0 && !i_wide_en) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= i_base_addr;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (r_wide && !r_byte) begin
                        r_row_buf[15:8] <= i_mem_data;
                        r_byte          <= 1'b1;
                        r_mem_rd        <= 1'b1;
                        r_mem_addr      <= r_mem_addr + ADDR_W'(1);
                        r_state         <= S_ISSUE;
                    end else begin
                        if (r_wide)
                            r_row_buf[7:0] <= i_mem_data;
                        else
                            r_row_buf <= {8'h00, i_mem_data};
                        r_state <= S_PLOT;
                    end
                end
                S_PLOT: begin
                    r_display  <= w_fb_next;
                    r_coll_acc <= r_coll_acc | w_row_coll;
                    if (r_row == r_last) begin
                        r_collision <= r_coll_acc | w_row_coll;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_row      <= r_row + 4'd1;
                        r_byte     <= 1'b0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_state    <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_mem_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_collision = r_collision;
    assign o_display   = r_display;

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// tb_chip8_sprite_blitter -- two instances (64x32 and 128x64) driven by the same
// commands and compared against a pixel-level reference model of sprite drawing.
module tb_chip8_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, clear;
    logic [7:0]  x_in, y_in;
    logic [3:0]  n_rows;
    logic        wide_en, clip;
    logic [11:0] base_addr;

    logic        rd_a, rd_b;
    logic [11:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic        busy_a, busy_b, done_a, done_b, coll_a, coll_b;
    logic [2047:0] disp_a;
    logic [8191:0] disp_b;

    logic [7:0]    mem [4096];
    logic [8191:0] m_a, m_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chip8_sprite_blitter #(.DISP_W(64), .DISP_H(32), .ADDR_W(12)) dut_a (
        .clk(clk), .reset(reset), .i_start(start), .i_clear(clear),
        .i_x_in(x_in), .i_y_in(y_in), .i_n_rows(n_rows), .i_wide_en(wide_en),
        .i_clip(clip), .i_base_addr(base_addr), .o_mem_rd(rd_a), .o_mem_addr(addr_a),
        .i_mem_data(data_a), .o_busy(busy_a), .o_done(done_a), .o_collision(coll_a),
        .o_display(disp_a)
    );

    chip8_sprite_blitter #(.DISP_W(128), .DISP_H(64), .ADDR_W(12)) dut_b (
        .clk(clk), .reset(reset), .i_start(start), .i_clear(clear),
        .i_x_in(x_in), .i_y_in(y_in), .i_n_rows(n_rows), .i_wide_en(wide_en),
        .i_clip(clip), .i_base_addr(base_addr), .o_mem_rd(rd_b), .o_mem_addr(addr_b),
        .i_mem_data(data_b), .o_busy(busy_b), .o_done(done_b), .o_collision(coll_b),
        .o_display(disp_b)
    );

    // Synchronous program RAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_a) data_a <= mem[addr_a];
        if (rd_b) data_b <= mem[addr_b];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_display(input string tag);
        for (int y = 0; y < 32; y++)
            check($sformatf("%s.a.row%0d", tag, y), 128'(disp_a[y*64 +: 64]), 128'(m_a[y*64 +: 64]));
        for (int y = 0; y < 64; y++)
            check($sformatf("%s.b.row%0d", tag, y), disp_b[y*128 +: 128], m_b[y*128 +: 128]);
    endtask

    // Reference: plot every set sprite pixel, one at a time, on a w x h screen.
    task automatic model_draw(input int w, input int h, input int x, input int y, input int n,
                              input int we, input int cl, input int base,
                              inout logic [8191:0] fb, output bit coll);
        int rows, bpr, px, py, idx;
        logic [7:0] bval;
        coll = 1'b0;
        if (n != 0)      begin rows = n;  bpr = 1; end
        else if (we != 0) begin rows = 16; bpr = 2; end
        else             begin rows = 0;  bpr = 1; end
        for (int r = 0; r < rows; r++)
            for (int b = 0; b < bpr; b++) begin
                bval = mem[(base + r*bpr + b) % 4096];
                for (int k = 0; k < 8; k++)
                    if (bval[7-k]) begin
                        px = (x % w) + 8*b + k;
                        py = (y % h) + r;
                        if (!(cl != 0 && (px >= w || py >= h))) begin
                            idx = (py % h) * w + (px % w);
                            if (fb[idx]) coll = 1'b1;
                            fb[idx] = ~fb[idx];
                        end
                    end
            end
    endtask

    task automatic run_cmd(input string tag, input int x, input int y, input int n,
                           input int we, input int cl, input int base, input bit poke);
        int rows, bpr, exp_lat, cycles, busy_bad, extra_done, idle_busy;
        int qa[$];
        int qb[$];
        int exp_q[$];
        bit ca, cb;
        if (n != 0)      begin rows = n;  bpr = 1; end
        else if (we != 0) begin rows = 16; bpr = 2; end
        else             begin rows = 0;  bpr = 1; end
        exp_lat = (rows == 0) ? 1 : 1 + rows * (bpr == 2 ? 5 : 3);
        for (int i = 0; i < rows * bpr; i++) exp_q.push_back((base + i) % 4096);
        model_draw(64, 32, x, y, n, we, cl, base, m_a, ca);
        model_draw(128, 64, x, y, n, we, cl, base, m_b, cb);

        x_in = 8'(x); y_in = 8'(y); n_rows = 4'(n); wide_en = we[0]; clip = cl[0];
        base_addr = 12'(base); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1; busy_bad = 0;
        while (1) begin
            if (busy_a !== 1'b1 || busy_b !== 1'b1) busy_bad++;
            if (rd_a) qa.push_back(int'(addr_a));
            if (rd_b) qb.push_back(int'(addr_b));
            if (done_a === 1'b1 || cycles >= 200) break;
            start = poke && (cycles == 4);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 128'(cycles), 128'(exp_lat));
        check({tag, ".done_b"}, 128'(done_b), 128'(1));
        check({tag, ".busy"}, 128'(busy_bad), 128'(0));
        check({tag, ".coll_a"}, 128'(coll_a), 128'(ca));
        check({tag, ".coll_b"}, 128'(coll_b), 128'(cb));
        check({tag, ".nreads_a"}, 128'(qa.size()), 128'(exp_q.size()));
        check({tag, ".nreads_b"}, 128'(qb.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s.addr%0d", tag, i), 128'(i < qa.size() ? qa[i] : -1), 128'(exp_q[i]));

        extra_done = 0; idle_busy = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a || done_b) extra_done++;
            if (busy_a || busy_b) idle_busy++;
        end
        check({tag, ".extra_done"}, 128'(extra_done), 128'(0));
        check({tag, ".idle_busy"}, 128'(idle_busy), 128'(0));
        check({tag, ".coll_held"}, 128'(coll_a), 128'(ca));
        check_display(tag);
    endtask

    task automatic do_clear(input string tag, input bit with_start);
        int seen;
        clear = 1'b1; start = with_start;
        x_in = 8'd3; y_in = 8'd3; n_rows = 4'd2; wide_en = 1'b0; clip = 1'b0; base_addr = 12'h200;
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0;
        m_a = '0; m_b = '0;
        seen = 0;
        repeat (4) begin
            if (busy_a || busy_b || done_a || done_b) seen++;
            @(posedge clk); #1;
        end
        check({tag, ".no_activity"}, 128'(seen), 128'(0));
        check_display(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, 128'({busy_a, busy_b}), 128'(0));
        check({tag, ".done"}, 128'({done_a, done_b}), 128'(0));
        check({tag, ".coll"}, 128'({coll_a, coll_b}), 128'(0));
        check({tag, ".rd"}, 128'({rd_a, rd_b}), 128'(0));
        check({tag, ".addr"}, 128'({addr_a, addr_b}), 128'(0));
        check_display(tag);
    endtask

    logic [8191:0] tmp;
    bit            tmp_c;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        start = 0; clear = 0; x_in = 0; y_in = 0; n_rows = 0; wide_en = 0; clip = 0; base_addr = 0;
        m_a = '0; m_b = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset");

        // Classic "0" glyph, then redraw erases it with collision.
        mem[12'h200] = 8'hF0; mem[12'h201] = 8'h90; mem[12'h202] = 8'h90;
        mem[12'h203] = 8'h90; mem[12'h204] = 8'hF0;
        run_cmd("zero", 0, 0, 5, 0, 0, 12'h200, 1'b0);
        check("zero.row0", 128'(disp_a[63:0]), 128'h0F);
        check("zero.row1", 128'(disp_a[127:64]), 128'h09);
        run_cmd("zero_redraw", 0, 0, 5, 0, 0, 12'h200, 1'b0);
        check("zero_redraw.coll", 128'(coll_a), 128'(1));
        check("zero_redraw.empty", 128'(|disp_a), 128'(0));

        // Edge wrap versus clip.
        mem[12'h400] = 8'hFF;
        run_cmd("wrap", 60, 31, 1, 0, 0, 12'h400, 1'b0);
        check("wrap.row31", 128'(disp_a[31*64 +: 64]), 128'hF000_0000_0000_000F);
        do_clear("clr1", 1'b0);
        run_cmd("clip", 60, 31, 1, 0, 1, 12'h400, 1'b0);
        check("clip.row31", 128'(disp_a[31*64 +: 64]), 128'hF000_0000_0000_0000);
        do_clear("clr2", 1'b0);
        run_cmd("xmod", 200, 31, 1, 0, 0, 12'h400, 1'b0);
        check("xmod.row31", 128'(disp_a[31*64 +: 64]), 128'h0000_0000_0000_FF00);
        do_clear("clr3", 1'b0);

        // 16x16 wide sprite with address wrap past 0xFFF.
        for (int i = 0; i < 32; i++) mem[(12'hFFE + i) % 4096] = 8'hFF;
        run_cmd("wide", 0, 0, 0, 1, 0, 12'hFFE, 1'b0);
        check("wide.b.row0", disp_b[127:0], 128'hFFFF);
        check("wide.b.row15", disp_b[15*128 +: 128], 128'hFFFF);
        check("wide.b.row16", disp_b[16*128 +: 128], 128'h0);

        // Empty command: immediate done, nothing read, display untouched.
        run_cmd("empty", 5, 5, 0, 0, 0, 12'h123, 1'b0);

        // start with clear: clear wins, no draw.
        do_clear("start_clear", 1'b1);

        // start pulsed mid-draw is ignored.
        run_cmd("poke", 10, 4, 5, 0, 0, 12'h200, 1'b1);

        // Reset during row 2 of a 5-row draw.
        do_clear("clr4", 1'b0);
        x_in = 8'd20; y_in = 8'd10; n_rows = 4'd5; wide_en = 1'b0; clip = 1'b0; base_addr = 12'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        tmp = '0;
        model_draw(64, 32, 20, 10, 2, 0, 0, 12'h200, tmp, tmp_c);
        check("midreset.partial", 128'(disp_a[11*64 +: 64]), 128'(tmp[11*64 +: 64]));
        check("midreset.busy", 128'(busy_a), 128'(1));
        #2 reset = 1'b1;
        #1;
        m_a = '0; m_b = '0;
        check_reset_outputs("midreset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        run_cmd("after_reset", 20, 10, 5, 0, 0, 12'h200, 1'b0);

        // Randomised commands against the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_clear($sformatf("rnd%0d.clr", i), 1'b0);
            run_cmd($sformatf("rnd%0d", i), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
